// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - mem_state_e : SRAM access tracker states (IDLE/WAIT/DONE)
//   - default parameter values for SRAM latency, register address width and
//     the stall performance counter width
//   - width of the internal SRAM wait counter
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int SRAM_WAIT_DEFAULT  = 6;
  localparam int REG_ADDR_W_DEFAULT = 4;
  localparam int CNT_W_DEFAULT      = 16;

  // Wait counter holds at most SRAM_WAIT-2 = 13 for the largest legal latency.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational data-hazard detector for the instruction in ID.
// Ports:
//   id_src1_i, id_src2_i        source registers of the ID instruction
//   id_use_src1_i, id_two_src_i which sources the ID instruction actually reads
//   exe_dest_i, exe_wb_en_i     destination / write-back of the EXE instruction
//   exe_mem_r_en_i              EXE instruction is a load
//   mem_dest_i, mem_wb_en_i     destination / write-back of the MEM instruction
//   forward_en_i                forwarding network is active
//   hazard_o                    ID must wait for an older result
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_use_src1_i,
  input  logic                  id_two_src_i,
  input  logic [REG_ADDR_W-1:0] exe_dest_i,
  input  logic                  exe_wb_en_i,
  input  logic                  exe_mem_r_en_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  mem_wb_en_i,
  input  logic                  forward_en_i,
  output logic                  hazard_o
);

  logic hz_exe;
  logic hz_mem;

  assign hz_exe = exe_wb_en_i &
                  ((id_use_src1_i & (exe_dest_i == id_src1_i)) |
                   (id_two_src_i  & (exe_dest_i == id_src2_i)));

  assign hz_mem = mem_wb_en_i &
                  ((id_use_src1_i & (mem_dest_i == id_src1_i)) |
                   (id_two_src_i  & (mem_dest_i == id_src2_i)));

  // With forwarding, only a load in EXE cannot be bypassed in time; without
  // forwarding, any pending write in EXE or MEM blocks the read.
  assign hazard_o = forward_en_i ? (hz_exe & exe_mem_r_en_i) : (hz_exe | hz_mem);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the 5-stage pipeline.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_*                     ID instruction source fields
//   exe_*                    EXE instruction destination / write-back / load
//   mem_*                    MEM instruction destination / write-back / SRAM req
//   forward_en               forwarding network enabled
//   branch_taken             EXE resolved a taken branch
//   pc_ld                    PC load enable
//   ifid_ld / ifid_clr       IF/ID load enable / flush
//   idex_ld / idex_clr       ID/EXE load enable / flush
//   exmem_ld                 EXE/MEM load enable
//   memwb_ld / memwb_clr     MEM/WB load enable / bubble insert
//   sram_busy                SRAM access in progress
//   hazard                   raw data hazard (before priority)
//   stall_cycles             saturating count of cycles with pc_ld=0
// SRAM_WAIT must lie in 2..15.
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT  = SRAM_WAIT_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  forward_en,
  input  logic                  branch_taken,
  output logic                  pc_ld,
  output logic                  ifid_ld,
  output logic                  ifid_clr,
  output logic                  idex_ld,
  output logic                  idex_clr,
  output logic                  exmem_ld,
  output logic                  memwb_ld,
  output logic                  memwb_clr,
  output logic                  sram_busy,
  output logic                  hazard,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(SRAM_WAIT - 2);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

  mem_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic                  mem_stall;

  // ---------------------------------------------------------------------------
  // Data hazard detection
  // ---------------------------------------------------------------------------
  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_use_src1_i  (id_use_src1),
    .id_two_src_i   (id_two_src),
    .exe_dest_i     (exe_dest),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_r_en_i (exe_mem_r_en),
    .mem_dest_i     (mem_dest),
    .mem_wb_en_i    (mem_wb_en),
    .forward_en_i   (forward_en),
    .hazard_o       (hazard)
  );

  // ---------------------------------------------------------------------------
  // SRAM access FSM. The request cycle (IDLE) plus SRAM_WAIT-2 WAIT cycles
  // form the frozen window; DONE is the cycle in which the pipeline advances.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          cnt_d = CNT_LOAD;
          // Minimum latency has no WAIT cycles: request cycle then DONE.
          state_d = (SRAM_WAIT == 2) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // Leave WAIT as the decremented count reaches zero.
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        // A back-to-back request is picked up in IDLE on the next cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_stall = mem_req & (state_q != DONE);
  assign sram_busy = (state_q == WAIT) | ((state_q == IDLE) & mem_req);

  // ---------------------------------------------------------------------------
  // Stage control priority: SRAM freeze > branch flush > hazard bubble.
  // A branch seen during the freeze stays asserted (EXE is frozen) and takes
  // effect in the DONE cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_ld     = 1'b1;
    ifid_ld   = 1'b1;
    ifid_clr  = 1'b0;
    idex_ld   = 1'b1;
    idex_clr  = 1'b0;
    exmem_ld  = 1'b1;
    memwb_ld  = 1'b1;
    memwb_clr = 1'b0;
    if (mem_stall) begin
      pc_ld     = 1'b0;
      ifid_ld   = 1'b0;
      idex_ld   = 1'b0;
      exmem_ld  = 1'b0;
      memwb_clr = 1'b1;
    end else if (branch_taken) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (hazard) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    if (!pc_ld && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int SW = 6;
  localparam int RW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic          id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en;
  logic          mem_wb_en, mem_req, forward_en, branch_taken;
  logic          pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr;
  logic          exmem_ld, memwb_ld, memwb_clr, sram_busy, hazard;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.SRAM_WAIT(SW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .forward_en(forward_en), .branch_taken(branch_taken),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_clr(ifid_clr),
    .idex_ld(idex_ld), .idex_clr(idex_clr), .exmem_ld(exmem_ld),
    .memwb_ld(memwb_ld), .memwb_clr(memwb_clr),
    .sram_busy(sram_busy), .hazard(hazard), .stall_cycles(stall_cycles)
  );

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The SRAM access is tracked as "which cycle of the access
  // is this" (1..SW); cycle SW is the one where the pipeline advances.
  // ---------------------------------------------------------------------------
  int            m_phase = 0;
  int            cur, m_next;
  logic [CW-1:0] m_stall = '0;
  logic          hz_e, hz_m, e_hazard, e_busy, e_mstall;
  logic          e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr;

  always_comb begin
    hz_e = exe_wb_en && ((id_use_src1 && exe_dest == id_src1) || (id_two_src && exe_dest == id_src2));
    hz_m = mem_wb_en && ((id_use_src1 && mem_dest == id_src1) || (id_two_src && mem_dest == id_src2));
    e_hazard = forward_en ? (hz_e && exe_mem_r_en) : (hz_e || hz_m);
    cur = (m_phase == 0) ? (mem_req ? 1 : 0) : m_phase;
    e_busy   = (cur >= 1) && (cur <= SW - 1);
    e_mstall = mem_req && (cur != SW);
    m_next   = (cur == 0 || cur == SW) ? 0 : cur + 1;
    {e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr} = 8'b11010110;
    if (e_mstall)
      {e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr} = 8'b00000011;
    else if (branch_taken)
      {e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr} = 8'b11111110;
    else if (e_hazard)
      {e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr} = 8'b00011110;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_stall = '0;
    end else begin
      if (!e_pc && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
      m_phase = m_next;
    end
  end

  // Compare process: every cycle outputs are meaningful.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("outputs",
            {22'd0, pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, memwb_ld, memwb_clr, sram_busy, hazard},
            {22'd0, e_pc, e_ifid, e_ifid_clr, e_idex, e_idex_clr, e_exmem, e_memwb, e_memwb_clr, e_busy, e_hazard});
      check("stall_cycles", {16'd0, stall_cycles}, {16'd0, m_stall});
    end
  end

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    id_use_src1 = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_wb_en = 0; mem_req = 0; forward_en = 0; branch_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ld", {27'd0, pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}, 32'h1f);
    check("rst_clr", {29'd0, ifid_clr, idex_clr, memwb_clr}, 32'h0);
    check("rst_busy_hz", {30'd0, sram_busy, hazard}, 32'h0);
    check("rst_stall", {16'd0, stall_cycles}, 32'd0);

    // SRAM access, 6 cycles
    next_cycle();
    mem_req = 1;
    for (int c = 1; c <= SW; c++) begin
      @(negedge clk);
      check($sformatf("mem_pc_ld_c%0d", c), {31'd0, pc_ld}, (c <= SW - 1) ? 32'd0 : 32'd1);
      check($sformatf("mem_memwb_clr_c%0d", c), {31'd0, memwb_clr}, (c <= SW - 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    mem_req = 0;
    @(negedge clk);
    check("mem_stall_cnt", {16'd0, stall_cycles}, 32'd5);

    // Load-use hazard with forwarding
    next_cycle();
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_use_src1 = 1;
    @(negedge clk);
    check("fwd_hazard", {28'd0, hazard, pc_ld, ifid_ld, idex_clr}, 32'b1001);
    next_cycle();
    exe_mem_r_en = 0;
    @(negedge clk);
    check("fwd_nohazard", {30'd0, hazard, pc_ld}, 32'b01);

    // MEM-stage hazard without forwarding
    next_cycle();
    clear_inputs();
    mem_wb_en = 1; mem_dest = 4'd7; id_two_src = 1; id_src2 = 4'd7;
    @(negedge clk);
    check("nofwd_hazard", {29'd0, hazard, pc_ld, ifid_ld}, 32'b100);

    // Hazard and branch together: branch wins, no stall counted
    next_cycle();
    clear_inputs();
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_use_src1 = 1; branch_taken = 1;
    @(negedge clk);
    check("br_hz", {28'd0, hazard, pc_ld, ifid_clr, idex_clr}, 32'b1111);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("br_hz_stall_cnt", {16'd0, stall_cycles}, 32'd7);

    // Branch during SRAM freeze: flush deferred to DONE
    next_cycle();
    mem_req = 1; branch_taken = 1;
    for (int c = 1; c <= SW; c++) begin
      @(negedge clk);
      check($sformatf("memb_flush_c%0d", c), {30'd0, ifid_clr, idex_clr}, (c == SW) ? 32'b11 : 32'b00);
      check($sformatf("memb_pc_c%0d", c), {31'd0, pc_ld}, (c == SW) ? 32'd1 : 32'd0);
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    check("memb_stall_cnt", {16'd0, stall_cycles}, 32'd12);

    // Reset asserted in WAIT
    next_cycle();
    mem_req = 1;
    next_cycle();
    next_cycle();
    #2;
    check("pre_rst_busy", {31'd0, sram_busy}, 32'd1);
    rst = 1; mem_req = 0;
    #1;
    check("async_rst_busy", {31'd0, sram_busy}, 32'd0);
    check("async_rst_pc", {31'd0, pc_ld}, 32'd1);
    check("async_rst_stall", {16'd0, stall_cycles}, 32'd0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("post_rst", {16'd0, stall_cycles, 14'd0, sram_busy, pc_ld}, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      next_cycle();
      id_src1      = RW'($urandom_range(0, 3));
      id_src2      = RW'($urandom_range(0, 3));
      exe_dest     = RW'($urandom_range(0, 3));
      mem_dest     = RW'($urandom_range(0, 3));
      id_use_src1  = $urandom_range(0, 1) == 1;
      id_two_src   = $urandom_range(0, 1) == 1;
      exe_wb_en    = $urandom_range(0, 1) == 1;
      exe_mem_r_en = $urandom_range(0, 2) == 0;
      mem_wb_en    = $urandom_range(0, 1) == 1;
      mem_req      = $urandom_range(0, 5) == 0 || (mem_req && $urandom_range(0, 3) != 0);
      forward_en   = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 4) == 0;
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the load-enable (ld) and clear (clr) inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers, plus the PC load.
- Three conditions are arbitrated: multi-cycle SRAM access in MEM, load-use/data hazard in ID, and a taken branch resolved in EXE.
- It also keeps a saturating stall-cycle performance counter.

Parameters:
- SRAM_WAIT, 6, total cycles a MEM-stage SRAM access occupies, including the request cycle; legal range 2..15.
- REG_ADDR_W, 4, register-file address width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1  in  REG_ADDR_W  first source register of the instruction in ID.
- id_src2  in  REG_ADDR_W  second source register of the instruction in ID.
- id_use_src1  in  1  ID instruction reads src1.
- id_two_src  in  1  ID instruction reads src2.
- exe_dest  in  REG_ADDR_W  destination register of the instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  REG_ADDR_W  destination register of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM instruction performs an SRAM read or write.
- forward_en  in  1  forwarding unit is enabled.
- branch_taken  in  1  EXE resolved a taken branch.
- pc_ld  out  1  PC load enable.
- ifid_ld  out  1  IF/ID load enable.
- ifid_clr  out  1  IF/ID flush.
- idex_ld  out  1  ID/EXE load enable.
- idex_clr  out  1  ID/EXE flush.
- exmem_ld  out  1  EXE/MEM load enable.
- memwb_ld  out  1  MEM/WB load enable.
- memwb_clr  out  1  MEM/WB bubble insert.
- sram_busy  out  1  an SRAM access is in progress.
- hazard  out  1  data hazard detected this cycle (before priority).
- stall_cycles  out  CNT_W  count of cycles with pc_ld=0.

Behaviour:
- Reset: state=IDLE, wait counter=0, stall_cycles=0. With all inputs 0 the outputs are: all *_ld=1, all *_clr=0, sram_busy=0, hazard=0.
- Outputs are combinational from state and inputs; only the FSM, the wait counter and stall_cycles are registered.
- Hazard detection:
  - hz_exe = exe_wb_en & ((id_use_src1 & exe_dest==id_src1) | (id_two_src & exe_dest==id_src2)).
  - hz_mem: same form, using mem_wb_en and mem_dest.
  - forward_en=1: hazard = hz_exe & exe_mem_r_en.
  - forward_en=0: hazard = hz_exe | hz_mem.
- Memory FSM states: IDLE, WAIT, DONE.
  - IDLE & mem_req: load cnt=SRAM_WAIT-2, go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==0, go to DONE.
  - DONE: go to IDLE unconditionally, even if mem_req is still high. The next instruction's request is seen in IDLE on the following cycle.
  - mem_stall = mem_req & (state!=DONE). The pipeline therefore freezes SRAM_WAIT-1 cycles and advances on cycle SRAM_WAIT.
  - sram_busy = (state==WAIT) | (state==IDLE & mem_req).
- Priority, highest first:
  1. mem_stall: pc_ld, ifid_ld, idex_ld, exmem_ld = 0; memwb_ld=1 with memwb_clr=1 (bubble); no other clears.
  2. branch_taken: all ld=1; ifid_clr=1; idex_clr=1. The branch overrides the hazard because the hazarding instruction is being flushed.
  3. hazard: pc_ld=0, ifid_ld=0; idex_ld=1 with idex_clr=1 (bubble); exmem_ld=1, memwb_ld=1.
  4. Otherwise: all ld=1, all clr=0.
- Branch during mem_stall: the EXE stage is frozen, so branch_taken stays high. The flush is applied in the DONE cycle; no capture register is needed.
- stall_cycles increments on every cycle with pc_ld=0 and saturates at all-ones.
- Reset asserted mid-WAIT: return to IDLE immediately and asynchronously. The outputs revert to the IDLE function of the current inputs.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the default SRAM_WAIT and the counter width constant.
- One sub-module, hazard_detect, is natural: purely combinational, producing hazard from the ID/EXE/MEM fields and forward_en.

Test Plan:
- Reset release, all inputs 0 -> all ld=1, clr=0, stall_cycles=0, state IDLE.
- SRAM_WAIT=6, mem_req held high for 6 cycles -> pc_ld=0 on cycles 1-5 with memwb_clr=1; cycle 6 all ld=1; stall_cycles=5.
- forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=4'd3, id_src1=4'd3, id_use_src1=1 -> hazard=1, pc_ld=0, ifid_ld=0, idex_clr=1 for one cycle. Same stimulus with exe_mem_r_en=0 -> hazard=0.
- forward_en=0, mem_wb_en=1, mem_dest=4'd7, id_two_src=1, id_src2=4'd7 -> hazard=1, stall.
- hazard=1 and branch_taken=1 together -> pc_ld=1, ifid_clr=1, idex_clr=1, stall_cycles unchanged.
- mem_req and branch_taken both high at the same time:
  - flushes stay low during the stall;
  - flushes are asserted in the DONE cycle.
  Separately, assert rst in the WAIT state -> next cycle: IDLE, counter 0, stall_cycles=0.
